fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
Fetch-stage next-PC generator for the 5-stage pipeline. Holds the fetch PC and drives it to instruction memory and to the branch history table lookup port. Combines the BHT taken bit with an internal direct-mapped branch target buffer (BTB) to pick the predicted next PC. Checks branch resolution from execute, raises flush and redirects on a mispredict, and produces the BHT update strobe.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value loaded at reset.
BTB_IDX_W, 6, log2 of BTB entries (64); index = PC[BTB_IDX_W+1:2], tag = PC[31:BTB_IDX_W+2].

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
stall  in  1  hold fetch PC (hazard unit).
fetch_pc  out  32  current fetch PC; also BHT lookup PC.
bht_predict_taken  in  1  BHT prediction for fetch_pc (combinational from BHT).
pred_taken  out  1  prediction used this cycle; pipelined alongside the instruction.
pred_next_pc  out  32  predicted next PC; pipelined alongside the instruction.
res_valid  in  1  execute stage holds a resolved control-transfer instruction.
res_pc  in  32  PC of the resolved instruction.
res_taken  in  1  actual direction.
res_target  in  32  actual taken target.
res_pred_next_pc  in  32  pred_next_pc carried down the pipe for this instruction.
flush  out  1  mispredict; kill the younger IF/ID/EX-front instructions.
bht_upd_en  out  1  = res_valid; drives BHT update enable.
bht_upd_pc  out  32  = res_pc.
bht_upd_taken  out  1  = res_taken.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; all BTB valid bits=0. The reset clears BTB valid bits only; tag and target contents are don't-care.
- During reset and in the first cycle after reset: pred_taken=0, pred_next_pc=RESET_PC+4, flush=0. These follow from the combinational paths below.
- BTB lookup is an asynchronous read indexed by fetch_pc.
  - hit = valid[idx] && tag[idx]==fetch_pc tag.
- pred_taken = hit && bht_predict_taken.
- pred_next_pc = pred_taken ? btb_target[idx] : fetch_pc+4 (32-bit wrap, carry discarded).
- correct_next = res_taken ? res_target : res_pc+4.
- flush = res_valid && (correct_next != res_pred_next_pc). This is combinational, the same cycle as res_valid.
- Next fetch_pc priority, registered on the rising edge:
  1. flush -> correct_next (overrides stall).
  2. stall -> hold.
  3. otherwise -> pred_next_pc.
- BTB write on the rising edge when res_valid && res_taken: valid=1, tag=res_pc tag, target=res_target.
  - Overwrites any aliasing entry.
  - Not-taken resolutions do not allocate or invalidate.
  - Write is independent of stall and flush.
- Same-cycle BTB write and lookup to the same index: the lookup returns old contents; the new entry is visible the next cycle.
- bht_upd_* are pure combinational pass-throughs with no latency. The BHT applies them at the same edge.
- Mispredict penalty is fixed: the redirected PC appears on fetch_pc exactly one cycle after flush=1.
- Reset asserted mid-operation forces the reset state immediately, regardless of stall or res_valid.

Decomposition:
- Shared package (cpu_pkg): RESET_PC default, BTB_IDX_W default, derived BTB_TAG_W = 30-BTB_IDX_W, PC width constant 32.
- One sub-module: btb_table.
  - Storage: valid/tag/target arrays, async read, sync write, async-low reset of valid bits.
  - Ports: clk, rst, rd_pc, hit, rd_target, wr_en, wr_pc, wr_target.
- fetch_pc_gen contains the PC register, the next-PC mux and the mispredict compare.

Test Plan:
- Reset with RESET_PC=0 -> fetch_pc=0x0; with no stall and bht_predict_taken=0, fetch_pc steps 0x4, 0x8, 0xC on successive edges; flush=0 throughout.
- res_valid=1, res_pc=0x10, res_taken=1, res_target=0x40, res_pred_next_pc=0x14 -> flush=1 that cycle; fetch_pc=0x40 next cycle; bht_upd_en=1, bht_upd_pc=0x10.
- Afterwards fetch reaches 0x10 with bht_predict_taken=1 -> pred_taken=1, pred_next_pc=0x40, next fetch_pc=0x40. With bht_predict_taken=0 instead -> pred_next_pc=0x14.
- Aliasing: with BTB_IDX_W=6, first train 0x10->0x40, then resolve 0x110 taken to 0x80 -> lookup at 0x10 misses (pred_next_pc=0x14); lookup at 0x110 hits with target 0x80.
- Flush overrides stall: stall=1 together with a mispredict whose correct_next=0x200 -> fetch_pc=0x200 next cycle. With stall=1 and no flush, fetch_pc holds its value for N cycles.
- Correct prediction: res_valid=1 with res_pred_next_pc == correct_next -> flush=0 and fetch_pc unaffected. Separately, rst pulsed low mid-sequence -> fetch_pc=RESET_PC immediately and a prior BTB hit becomes a miss.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants for the fetch stage
package cpu_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int BTB_IDX_W_DEF = 6;
  localparam int BTB_TAG_W = 30 - BTB_IDX_W_DEF;
endpackage

// File: rtl/btb_table.sv
// btb_table: direct-mapped branch target buffer, async read, sync write
module btb_table
  import cpu_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W_DEF,
  parameter int TAG_W = BTB_TAG_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] rd_pc,
  output logic            hit,
  output logic [PC_W-1:0] rd_target,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic [PC_W-1:0] wr_target
);
  localparam int N = 1 << IDX_W;
  logic [N-1:0]      valid;
  logic [TAG_W-1:0]  tags    [N];
  logic [PC_W-1:0]   targets [N];
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              unused_bits;
  assign rd_idx      = rd_pc[IDX_W+1:2];
  assign wr_idx      = wr_pc[IDX_W+1:2];
  assign unused_bits = ^{rd_pc[1:0], wr_pc[1:0]};
  assign hit         = valid[rd_idx] && tags[rd_idx] == rd_pc[PC_W-1:IDX_W+2];
  assign rd_target   = targets[rd_idx];
  // only valid bits are reset; tag/target contents are masked by valid
  always_ff @(posedge clk or negedge rst)
    if (!rst) valid <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  always_ff @(posedge clk)
    if (wr_en) begin
      tags[wr_idx]    <= wr_pc[PC_W-1:IDX_W+2];
      targets[wr_idx] <= wr_target;
    end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register with BTB/BHT next-PC prediction and mispredict redirect
module fetch_pc_gen
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BTB_IDX_W = BTB_IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] fetch_pc,
  input  logic        bht_predict_taken,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic [31:0] res_pred_next_pc,
  output logic        flush,
  output logic        bht_upd_en,
  output logic [31:0] bht_upd_pc,
  output logic        bht_upd_taken
);
  logic        hit;
  logic [31:0] btb_target, correct_next;
  btb_table #(.IDX_W(BTB_IDX_W), .TAG_W(30 - BTB_IDX_W)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (fetch_pc),
    .hit       (hit),
    .rd_target (btb_target),
    .wr_en     (res_valid && res_taken),
    .wr_pc     (res_pc),
    .wr_target (res_target)
  );
  always_comb begin
    pred_taken   = hit && bht_predict_taken;
    pred_next_pc = pred_taken ? btb_target : fetch_pc + 32'd4;
    correct_next = res_taken ? res_target : res_pc + 32'd4;
    flush        = res_valid && correct_next != res_pred_next_pc;
  end
  assign bht_upd_en    = res_valid;
  assign bht_upd_pc    = res_pc;
  assign bht_upd_taken = res_taken;
  // a redirect wins over a hazard stall so the mispredict penalty stays fixed
  always_ff @(posedge clk or negedge rst)
    if (!rst) fetch_pc <= RESET_PC;
    else if (flush) fetch_pc <= correct_next;
    else if (!stall) fetch_pc <= pred_next_pc;
endmodule
